// File: rtl/no_overflow_serial_subtractor_if.sv
// Operand/result handshake bundle for the serial saturating subtractor.
// The master side produces operands and consumes results; the slave is the subtractor.
interface no_overflow_serial_subtractor_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             PO;
    logic             NO;

    modport master (
        output in_valid, in_signed, A, B, out_ready,
        input  in_ready, out_valid, result, PO, NO
    );

    modport slave (
        input  in_valid, in_signed, A, B, out_ready,
        output in_ready, out_valid, result, PO, NO
    );
endinterface

// File: rtl/no_overflow_serial_subtractor.sv
// Multi-cycle saturating subtractor: CHUNK bits per cycle, LSB first, borrow chained between slices.
// Define SAT_SUB_STICKY_EN to build the sticky overflow flags; otherwise they read constant 0.
module no_overflow_serial_subtractor #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic sticky_clr,
    output logic sticky_po,
    output logic sticky_no,
    no_overflow_serial_subtractor_if.slave bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    generate
        if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("no_overflow_serial_subtractor: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg, b_reg, diff_reg, result_reg;
    logic             signed_reg, borrow_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             in_ready_reg, out_valid_reg, po_reg, no_reg;

    logic [CHUNK-1:0] slice_a, slice_b, slice_d;
    logic             slice_borrow;
    logic [WIDTH-1:0] raw_diff, sat_next;
    logic             last_slice, po_next, no_next;

    always_comb begin
        slice_a = a_reg[cnt_reg*CHUNK +: CHUNK];
        slice_b = b_reg[cnt_reg*CHUNK +: CHUNK];
        {slice_borrow, slice_d} = {1'b0, slice_a} - {1'b0, slice_b} - {{CHUNK{1'b0}}, borrow_reg};
        // Full difference including the slice being computed this cycle.
        raw_diff = diff_reg;
        raw_diff[cnt_reg*CHUNK +: CHUNK] = slice_d;
        last_slice = (cnt_reg == LAST);
        po_next = signed_reg & ~a_reg[WIDTH-1] & b_reg[WIDTH-1] & raw_diff[WIDTH-1];
        // Unsigned underflow is exactly the borrow out of the top slice.
        no_next = signed_reg ? (a_reg[WIDTH-1] & ~b_reg[WIDTH-1] & ~raw_diff[WIDTH-1])
                             : slice_borrow;
        if (po_next)
            sat_next = {1'b0, {(WIDTH-1){1'b1}}};
        else if (no_next)
            sat_next = signed_reg ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
        else
            sat_next = raw_diff;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            diff_reg      <= '0;
            result_reg    <= '0;
            signed_reg    <= 1'b0;
            borrow_reg    <= 1'b0;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            po_reg        <= 1'b0;
            no_reg        <= 1'b0;
        end else if (flush) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg        <= bus.A;
                        b_reg        <= bus.B;
                        signed_reg   <= bus.in_signed;
                        diff_reg     <= '0;
                        cnt_reg      <= '0;
                        borrow_reg   <= 1'b0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= CALC;
                    end
                end
                CALC: begin
                    diff_reg   <= raw_diff;
                    borrow_reg <= slice_borrow;
                    cnt_reg    <= cnt_reg + CNT_W'(1);
                    if (last_slice) begin
                        result_reg    <= sat_next;
                        po_reg        <= po_next;
                        no_reg        <= no_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.result    = result_reg;
    assign bus.PO        = po_reg;
    assign bus.NO        = no_reg;

`ifdef SAT_SUB_STICKY_EN
    logic sticky_po_reg, sticky_no_reg, finish_op;

    // Flags latch on the same edge that enters DONE; a set beats a same-cycle clear.
    assign finish_op = (state_reg == CALC) && last_slice && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_po_reg <= 1'b0;
            sticky_no_reg <= 1'b0;
        end else begin
            sticky_po_reg <= (sticky_po_reg & ~sticky_clr) | (finish_op & po_next);
            sticky_no_reg <= (sticky_no_reg & ~sticky_clr) | (finish_op & no_next);
        end
    end

    assign sticky_po = sticky_po_reg;
    assign sticky_no = sticky_no_reg;
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = sticky_clr;
    assign sticky_po = 1'b0;
    assign sticky_no = 1'b0;
`endif
endmodule

// File: tb/tb_no_overflow_serial_subtractor.sv
// Directed-vector bench for the serial saturating subtractor at WIDTH=8, CHUNK=4.
module tb_no_overflow_serial_subtractor;
    localparam int W = 8;
    localparam int C = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic sticky_clr = 1'b0;
    logic sticky_po, sticky_no;

    int total = 0;
    int bad = 0;

    no_overflow_serial_subtractor_if #(.WIDTH(W)) bus ();

    no_overflow_serial_subtractor #(.WIDTH(W), .CHUNK(C)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .sticky_clr (sticky_clr),
        .sticky_po  (sticky_po),
        .sticky_no  (sticky_no),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       po;
        logic       no;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic run_op(input logic s, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] r, output logic po, output logic no, output int lat);
        int k;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_signed = s;
        bus.A         = a;
        bus.B         = b;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) check("accept_timeout", 32'(k), 32'd0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r  = bus.result;
        po = bus.PO;
        no = bus.NO;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        $display("op s=%0d A=%02h B=%02h -> result=%02h PO=%0d NO=%0d lat=%0d", s, a, b, r, po, no, lat);
    endtask

    task automatic wait_out_valid(input string name);
        int k;
        k = 0;
        while (!bus.out_valid && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 10) check(name, 32'(bus.out_valid), 32'd1);
    endtask

    logic [7:0] r;
    logic       po, no;
    int         lat;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_signed = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.out_ready = 1'b0;

        vecs[0]  = '{1'b1, 8'h10, 8'h03, 8'h0D, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h7F, 8'hFF, 8'h7F, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 8'h80, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 8'h05, 8'h07, 8'h00, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'h80, 8'h80, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'h55, 8'h55, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h33, 8'h00, 8'h33, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 8'h00, 8'h80, 8'h7F, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 8'hFF, 8'h7F, 8'h80, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h80, 8'h81, 8'h00, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 8'h3C, 8'hC4, 8'h78, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 8'h01, 8'h00, 1'b0, 1'b1};

        // Reset state
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result",    32'(bus.result),    32'd0);
        check("rst_po",        32'(bus.PO),        32'd0);
        check("rst_no",        32'(bus.NO),        32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_sticky_po", 32'(sticky_po),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].s, vecs[i].a, vecs[i].b, r, po, no, lat);
            check($sformatf("vec%0d_result", i), 32'(r),   32'(vecs[i].r));
            check($sformatf("vec%0d_po", i),     32'(po),  32'(vecs[i].po));
            check($sformatf("vec%0d_no", i),     32'(no),  32'(vecs[i].no));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
        end

        // Back-pressure: result held for 5 stalled cycles, second op waits for the handshake
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_signed = 1'b1; bus.A = 8'h7F; bus.B = 8'hFF;
        @(posedge clk);
        #1;
        bus.in_signed = 1'b0; bus.A = 8'hFF; bus.B = 8'h01;
        wait_out_valid("stall_out_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_result",    32'(bus.result),    32'h7F);
            check("stall_po",        32'(bus.PO),        32'd1);
            check("stall_in_ready",  32'(bus.in_ready),  32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        check("stall_release_valid", 32'(bus.out_valid), 32'd0);
        check("stall_bubble_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check("stall_op2_accepted", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 check("stall_op2_early", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("stall_op2_valid",  32'(bus.out_valid), 32'd1);
        check("stall_op2_result", 32'(bus.result),    32'hFE);
        $display("op s=0 A=ff B=01 -> result=%02h after stall", bus.result);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;

        // Flush during the first CALC cycle
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_signed = 1'b0; bus.A = 8'h10; bus.B = 8'h01;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 check("flush_no_valid", 32'(bus.out_valid), 32'd0);
        end
        check("flush_result_held", 32'(bus.result), 32'hFE);
        $display("flush op s=0 A=10 B=01 -> discarded");

`ifdef SAT_SUB_STICKY_EN
        run_op(1'b1, 8'h7F, 8'hFF, r, po, no, lat);
        check("sticky_po_set", 32'(sticky_po), 32'd1);
        run_op(1'b1, 8'h10, 8'h03, r, po, no, lat);
        check("sticky_po_kept", 32'(sticky_po), 32'd1);
        check("sticky_no_clean", 32'(sticky_no), 32'd0);
        @(negedge clk);
        sticky_clr = 1'b1;
        @(posedge clk);
        #1 sticky_clr = 1'b0;
        check("sticky_po_cleared", 32'(sticky_po), 32'd0);
        run_op(1'b1, 8'h80, 8'h01, r, po, no, lat);
        check("sticky_no_set", 32'(sticky_no), 32'd1);
`else
        run_op(1'b1, 8'h7F, 8'hFF, r, po, no, lat);
        check("sticky_po_off", 32'(sticky_po), 32'd0);
        run_op(1'b0, 8'h05, 8'h07, r, po, no, lat);
        check("sticky_no_off", 32'(sticky_no), 32'd0);
`endif

        // Asynchronous reset in the middle of CALC
        run_op(1'b1, 8'h00, 8'h80, r, po, no, lat);
        check("pre_rst_po", 32'(po), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_signed = 1'b1; bus.A = 8'h10; bus.B = 8'h03;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_result",    32'(bus.result),    32'd0);
        check("midrst_po",        32'(bus.PO),        32'd0);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        check("midrst_sticky_po", 32'(sticky_po),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 8'hFF, 8'h01, r, po, no, lat);
        check("post_rst_result", 32'(r), 32'hFE);
        check("post_rst_latency", 32'(lat), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
